// File: rtl/chroni_line_fetcher.sv
// chroni_line_fetcher: fetches one scanline from VRAM into the line buffer.
// 8bpp bytes go straight in; 1bpp bytes go in as bitmap-expand writes.
//
// Ports:
//   clk, reset            single clock, async active-high reset
//   start, mode_1bpp,     line request and its parameters (latched on
//   src_addr, byte_count, start while idle)
//   dst_addr, color_on,
//   color_off
//   busy, done            line in progress / one-cycle completion pulse
//   vram_rd_*             single-outstanding VRAM read (req held to ack)
//   lb_wr_*, lb_bitmap_*  registered line-buffer write port
//   lb_busy               line buffer is expanding a bitmap byte
module chroni_line_fetcher #(
  parameter int VRAM_AW    = 16,
  parameter int LB_AW      = 11,
  parameter int LB_SIZE    = 1280,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode_1bpp,
  input  logic [VRAM_AW-1:0] src_addr,
  input  logic [10:0]        byte_count,
  input  logic [LB_AW-1:0]   dst_addr,
  input  logic [7:0]         color_on,
  input  logic [7:0]         color_off,
  output logic               busy,
  output logic               done,
  output logic               vram_rd_req,
  output logic [VRAM_AW-1:0] vram_rd_addr,
  input  logic               vram_rd_ack,
  input  logic [7:0]         vram_rd_data,
  output logic               lb_wr_en,
  output logic [LB_AW-1:0]   lb_wr_addr,
  output logic [7:0]         lb_wr_data,
  output logic [3:0]         lb_bitmap_bits,
  output logic [7:0]         lb_bitmap_on,
  output logic [7:0]         lb_bitmap_off,
  input  logic               lb_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = LB_AW + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic               mode_q;
  logic [VRAM_AW-1:0] src_q;
  logic [10:0]        count_q;
  logic [10:0]        fetched;
  logic [10:0]        popped;
  logic [LB_AW:0]     pix;
  logic [3:0]         gap;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  logic          run;
  logic          ack_v;
  logic          pop_ok;
  logic          pop;
  logic          last_pop;
  logic          issue;
  logic          clip;
  logic [CW-1:0] cnt_after;
  logic [SW-1:0] step;
  logic [SW-1:0] pix_sum;
  logic [LB_AW:0] pix_next;

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

  assign run      = (state == S_RUN);
  assign ack_v    = run && vram_rd_req && vram_rd_ack;
  // 1bpp waits out the line buffer's busy lag plus its expansion.
  assign pop_ok   = mode_q ? (!lb_busy && gap == 4'd0) : 1'b1;
  assign pop      = run && (fifo_cnt != '0) && pop_ok;
  assign last_pop = pop && (popped == count_q - 11'd1);

  assign cnt_after = fifo_cnt + CW'(ack_v) - CW'(pop);
  // Next request may go out in the ack cycle itself.
  assign issue = run && (!vram_rd_req || ack_v) &&
                 (fetched < count_q) &&
                 (cnt_after < CW'(FIFO_DEPTH));

  assign step     = mode_q ? SW'(8) : SW'(1);
  assign pix_sum  = {1'b0, pix} + step;
  assign clip     = pix_sum > SW'(LB_SIZE);
  // Pixel counter saturates so a long line never wraps back in range.
  assign pix_next = pix_sum[SW-1] ? '1 : pix_sum[LB_AW:0];

  always_ff @(posedge clk) begin
    if (ack_v) fifo_mem[wr_ptr] <= vram_rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      mode_q         <= 1'b0;
      src_q          <= '0;
      count_q        <= '0;
      fetched        <= '0;
      popped         <= '0;
      pix            <= '0;
      gap            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      vram_rd_req    <= 1'b0;
      vram_rd_addr   <= '0;
      lb_wr_en       <= 1'b0;
      lb_wr_addr     <= '0;
      lb_wr_data     <= '0;
      lb_bitmap_bits <= '0;
      lb_bitmap_on   <= '0;
      lb_bitmap_off  <= '0;
    end else begin
      lb_wr_en       <= 1'b0;
      lb_bitmap_bits <= 4'd0;
      fifo_cnt       <= cnt_after;

      if (ack_v) wr_ptr <= wr_ptr + PW'(1);

      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        popped     <= popped + 11'd1;
        pix        <= pix_next;
        lb_wr_en   <= !clip;
        lb_wr_addr <= pix[LB_AW-1:0];
        lb_wr_data <= fifo_mem[rd_ptr];
        if (mode_q && !clip) lb_bitmap_bits <= 4'd8;
      end

      if (pop && mode_q && !clip) gap <= 4'd9;
      else if (gap != 4'd0)      gap <= gap - 4'd1;

      if (issue) begin
        vram_rd_req  <= 1'b1;
        vram_rd_addr <= src_q + VRAM_AW'(fetched);
        fetched      <= fetched + 11'd1;
      end else if (ack_v) begin
        vram_rd_req  <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q        <= mode_1bpp;
            src_q         <= src_addr;
            count_q       <= byte_count;
            pix           <= {1'b0, dst_addr};
            lb_bitmap_on  <= color_on;
            lb_bitmap_off <= color_off;
            fetched       <= '0;
            popped        <= '0;
            gap           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            state <= (byte_count == 11'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (last_pop) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!mode_q || (gap == 4'd0 && !lb_busy))
            state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chroni_line_fetcher.sv
// tb_chroni_line_fetcher: randomized self-checking bench with a VRAM
// responder, a behavioural line-buffer model and a per-line expectation model.
module tb_chroni_line_fetcher;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode_1bpp;
  logic [15:0] src_addr;
  logic [10:0] byte_count;
  logic [10:0] dst_addr;
  logic [7:0]  color_on;
  logic [7:0]  color_off;
  logic        busy;
  logic        done;
  logic        vram_rd_req;
  logic [15:0] vram_rd_addr;
  logic        vram_rd_ack;
  logic [7:0]  vram_rd_data;
  logic        lb_wr_en;
  logic [10:0] lb_wr_addr;
  logic [7:0]  lb_wr_data;
  logic [3:0]  lb_bitmap_bits;
  logic [7:0]  lb_bitmap_on;
  logic [7:0]  lb_bitmap_off;
  logic        lb_busy;

  chroni_line_fetcher dut (
    .clk(clk), .reset(reset), .start(start),
    .mode_1bpp(mode_1bpp), .src_addr(src_addr),
    .byte_count(byte_count), .dst_addr(dst_addr),
    .color_on(color_on), .color_off(color_off),
    .busy(busy), .done(done),
    .vram_rd_req(vram_rd_req), .vram_rd_addr(vram_rd_addr),
    .vram_rd_ack(vram_rd_ack), .vram_rd_data(vram_rd_data),
    .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr),
    .lb_wr_data(lb_wr_data), .lb_bitmap_bits(lb_bitmap_bits),
    .lb_bitmap_on(lb_bitmap_on), .lb_bitmap_off(lb_bitmap_off),
    .lb_busy(lb_busy)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
    logic [3:0]  bits;
    logic [7:0]  on;
    logic [7:0]  off;
  } wr_t;

  int   tests;
  int   fails;
  int   cyc;
  logic [7:0] vmem [65536];
  logic [7:0] lbmem [2048];
  int   rd_q[$];
  wr_t  wr_q[$];
  int   exp_rd[$];
  wr_t  exp_wr[$];
  int   done_cnt, done_cyc, viol;
  int   last_wr_cyc, busy_lo, busy_hi;
  int   lat_lo, lat_hi;
  bit   force_busy, chk_occ, busy_at_done, prev_busy;
  bit   pend;
  int   pend_addr, wait_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit hit, want finish");
    $fatal(1);
  end

  // VRAM responder and line-buffer model, evaluated mid-cycle.
  initial begin
    wr_t w;
    bit win;
    vram_rd_ack = 1'b0; vram_rd_data = 8'h00; lb_busy = 1'b0;
    pend = 0; cyc = 0; last_wr_cyc = -100;
    busy_lo = 0; busy_hi = -1; prev_busy = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (vram_rd_ack) vram_rd_ack = 1'b0;
      if (pend) begin
        if (vram_rd_req && vram_rd_addr != pend_addr[15:0]) viol++;
        if (wait_cnt <= 1) begin
          vram_rd_ack  = 1'b1;
          vram_rd_data = vmem[pend_addr];
          pend = 0;
        end else wait_cnt--;
      end else if (vram_rd_req) begin
        pend = 1;
        pend_addr = int'(vram_rd_addr);
        wait_cnt = int'($urandom_range(lat_hi, lat_lo));
        rd_q.push_back(pend_addr);
      end
      win = (cyc >= busy_lo && cyc <= busy_hi);
      lb_busy = force_busy || win;
      if (lb_wr_en) begin
        if (lb_bitmap_bits == 4'd8) begin
          if (win || prev_busy) viol++;
          if (cyc - last_wr_cyc < 10) viol++;
          last_wr_cyc = cyc;
          busy_lo = cyc + 1;
          busy_hi = cyc + 8;
          for (int i = 0; i < 8; i++)
            lbmem[(int'(lb_wr_addr) + i) % 2048] =
              lb_wr_data[7-i] ? lb_bitmap_on : lb_bitmap_off;
        end else begin
          lbmem[lb_wr_addr] = lb_wr_data;
        end
        w.addr = lb_wr_addr; w.data = lb_wr_data;
        w.bits = lb_bitmap_bits;
        w.on = lb_bitmap_on; w.off = lb_bitmap_off;
        wr_q.push_back(w);
      end
      if (!lb_wr_en && lb_bitmap_bits != 4'd0) viol++;
      if (chk_occ && (rd_q.size() - wr_q.size() > 2)) viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      prev_busy = lb_busy;
    end
  end

  function automatic void build_exp(bit m, int src, int cnt,
                                    int dst, int on, int off);
    wr_t w;
    int p, px;
    exp_rd.delete(); exp_wr.delete();
    p = m ? 8 : 1;
    for (int i = 0; i < cnt; i++) begin
      exp_rd.push_back((src + i) % 65536);
      px = dst + i * p;
      if (px + p <= 1280) begin
        w.addr = 11'(px);
        w.data = vmem[(src + i) % 65536];
        w.bits = m ? 4'd8 : 4'd0;
        w.on = 8'(on); w.off = 8'(off);
        exp_wr.push_back(w);
      end
    end
  endfunction

  function automatic int diff_rd();
    if (rd_q.size() != exp_rd.size()) return -2;
    foreach (exp_rd[i]) if (rd_q[i] != exp_rd[i]) return i;
    return -1;
  endfunction

  function automatic int diff_wr();
    if (wr_q.size() != exp_wr.size()) return -2;
    foreach (exp_wr[i]) if (wr_q[i] !== exp_wr[i]) return i;
    return -1;
  endfunction

  function automatic logic [58:0] outs();
    return {busy, done, vram_rd_req, vram_rd_addr, lb_wr_en,
            lb_wr_addr, lb_wr_data, lb_bitmap_bits,
            lb_bitmap_on, lb_bitmap_off};
  endfunction

  task automatic run_line(input bit m, input int src, input int cnt,
                          input int dst, input int on, input int off,
                          output int lat);
    int p;
    @(negedge clk);
    p = m ? 8 : 1;
    rd_q.delete(); wr_q.delete();
    done_cnt = 0; viol = 0; done_cyc = 0; busy_at_done = 0;
    chk_occ = (dst + cnt * p <= 1280);
    mode_1bpp = m; src_addr = 16'(src); byte_count = 11'(cnt);
    dst_addr = 11'(dst); color_on = 8'(on); color_off = 8'(off);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode_1bpp = ~m; src_addr = 16'($urandom);
    byte_count = 11'($urandom); dst_addr = 11'($urandom);
    color_on = 8'($urandom); color_off = 8'($urandom);
    lat = -1;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin lat = i; break; end
      @(negedge clk);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic chk_line(input string nm, input int lat);
    tests++;
    if (lat < 0) begin
      fails++;
      $display("FAIL %s timeout: no done, want done", nm);
    end
    tests++;
    if (diff_rd() != -1) begin
      fails++;
      $display("FAIL %s reads: got %0d (bad idx %0d), want %0d",
               nm, rd_q.size(), diff_rd(), exp_rd.size());
    end
    tests++;
    if (diff_wr() != -1) begin
      fails++;
      $display("FAIL %s writes: got %0d (bad idx %0d), want %0d",
               nm, wr_q.size(), diff_wr(), exp_wr.size());
    end
    tests++;
    if (done_cnt !== 1 || viol !== 0) begin
      fails++;
      $display("FAIL %s done/protocol: done=%0d viol=%0d, want 1/0",
               nm, done_cnt, viol);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want 0", outs());
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_8bpp();
    int lat;
    logic [7:0] d [4];
    d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC; d[3] = 8'hDD;
    for (int i = 0; i < 4; i++) vmem[16'h1000 + i] = d[i];
    lat_lo = 1; lat_hi = 1;
    build_exp(0, 16'h1000, 4, 10, 8'h12, 8'h34);
    run_line(0, 16'h1000, 4, 10, 8'h12, 8'h34, lat);
    chk_line("8bpp", lat);
  endtask

  task automatic test_1bpp();
    int lat, bad;
    logic [7:0] px;
    vmem[16'h0400] = 8'hA5; vmem[16'h0401] = 8'h3C;
    for (int i = 0; i < 16; i++) lbmem[i] = 8'h55;
    lat_lo = 1; lat_hi = 2;
    build_exp(1, 16'h0400, 2, 0, 8'h0F, 8'h00);
    run_line(1, 16'h0400, 2, 0, 8'h0F, 8'h00, lat);
    chk_line("1bpp", lat);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      px = vmem[16'h0400 + i / 8][7 - i % 8] ? 8'h0F : 8'h00;
      if (lbmem[i] !== px) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL 1bpp_pixels: %0d pixels wrong, want 0", bad);
    end
    tests++;
    if (done_cyc <= busy_hi) begin
      fails++;
      $display("FAIL 1bpp_done_after_busy: done cyc %0d, want > %0d",
               done_cyc, busy_hi);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    for (int i = 0; i < 8; i++) vmem[16'h3000 + i] = 8'($urandom);
    lat_lo = 1; lat_hi = 6;
    build_exp(1, 16'h3000, 8, 64, 8'hE1, 8'h1E);
    fork
      run_line(1, 16'h3000, 8, 64, 8'hE1, 8'h1E, lat);
      begin
        repeat (4) @(negedge clk);
        force_busy = 1;
        repeat (20) @(negedge clk);
        force_busy = 0;
      end
    join
    chk_line("backpressure", lat);
  endtask

  task automatic test_clip();
    int lat;
    lat_lo = 1; lat_hi = 3;
    build_exp(1, 16'h5000, 3, 1272, 8'hFF, 8'h01);
    run_line(1, 16'h5000, 3, 1272, 8'hFF, 8'h01, lat);
    chk_line("clip_1bpp", lat);
    tests++;
    if (wr_q.size() != 1 || exp_wr.size() != 1) begin
      fails++;
      $display("FAIL clip_1bpp_count: got %0d writes, want 1",
               wr_q.size());
    end
    build_exp(0, 16'h5100, 4, 1278, 8'h00, 8'h00);
    run_line(0, 16'h5100, 4, 1278, 8'h00, 8'h00, lat);
    chk_line("clip_8bpp", lat);
  endtask

  task automatic test_zero_count();
    int lat;
    build_exp(0, 16'h0100, 0, 5, 8'h00, 8'h00);
    run_line(0, 16'h0100, 0, 5, 8'h00, 8'h00, lat);
    chk_line("zero", lat);
    tests++;
    if (lat !== 0 || busy_at_done !== 1'b1) begin
      fails++;
      $display("FAIL zero_timing: lat=%0d busy=%0b, want 0/1",
               lat, busy_at_done);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_busy_drop: got %0b, want 0", busy);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    lat_lo = 2; lat_hi = 2;
    build_exp(0, 16'h6000, 6, 300, 8'h44, 8'h55);
    fork
      run_line(0, 16'h6000, 6, 300, 8'h44, 8'h55, lat);
      begin
        repeat (5) @(negedge clk);
        start = 1'b1; mode_1bpp = 1'b1;
        src_addr = 16'h7777; byte_count = 11'd3;
        @(negedge clk);
        start = 1'b0;
      end
    join
    chk_line("start_ignored", lat);
  endtask

  task automatic test_mid_reset();
    int lat;
    bit hit;
    lat_lo = 5; lat_hi = 5;
    @(negedge clk);
    rd_q.delete(); wr_q.delete(); chk_occ = 0;
    mode_1bpp = 0; src_addr = 16'h2000; byte_count = 11'd8;
    dst_addr = 11'd100; color_on = 8'h00; color_off = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (wr_q.size() >= 2 && vram_rd_req && pend && wait_cnt >= 3) begin
        hit = 1;
        break;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_reset_setup: no outstanding req after 2 writes");
    end
    reset = 1'b1;
    #1;
    tests++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %h, want 0", outs());
    end
    @(negedge clk);
    reset = 1'b0;
    rd_q.delete(); wr_q.delete(); done_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || done_cnt != 0 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_quiet: rd=%0d wr=%0d done=%0d busy=%0b, want 0",
               rd_q.size(), wr_q.size(), done_cnt, busy);
    end
    lat_lo = 1; lat_hi = 3;
    build_exp(0, 16'h2000, 8, 100, 8'h00, 8'h00);
    run_line(0, 16'h2000, 8, 100, 8'h00, 8'h00, lat);
    chk_line("after_reset", lat);
  endtask

  task automatic test_random();
    int lat, src, cnt, dst, on, off;
    bit m;
    lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 6; n++) begin
      m   = 1'($urandom);
      src = (n == 0) ? 16'hFFFC : int'($urandom_range(65535, 0));
      cnt = int'($urandom_range(24, 1));
      dst = int'($urandom_range(1400, 0));
      on  = int'($urandom_range(255, 0));
      off = int'($urandom_range(255, 0));
      build_exp(m, src, cnt, dst, on, off);
      run_line(m, src, cnt, dst, on, off, lat);
      chk_line($sformatf("random%0d", n), lat);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; start = 1'b0; mode_1bpp = 1'b0;
    src_addr = '0; byte_count = '0; dst_addr = '0;
    color_on = '0; color_off = '0;
    force_busy = 0; chk_occ = 0; viol = 0; done_cnt = 0;
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 65536; i++) vmem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) lbmem[i] = 8'h00;
    test_reset();
    test_8bpp();
    test_1bpp();
    test_backpressure();
    test_clip();
    test_zero_count();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
